// File: rtl/mathblock_mac_accum.sv
// Pipelined multiply-accumulate: per-beat (A*B)+C, framed add/subtract accumulation, one result per frame.
// Build option MATHBLOCK_MAC_SAT_EN: clamp accumulator and result on overflow instead of wrapping.
`timescale 1ns/1ps
module mathblock_mac_accum #(
   parameter int A_WIDTH   = 18,
   parameter int B_WIDTH   = 18,
   parameter int C_WIDTH   = 44,
   parameter int ACC_WIDTH = 44,
   parameter int SIGNED    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [A_WIDTH-1:0]   in_a,
   input  logic [B_WIDTH-1:0]   in_b,
   input  logic [C_WIDTH-1:0]   in_c,
   input  logic                 in_sub,
   input  logic                 in_first,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_p,
   output logic                 out_ovf
);

   localparam int   PW    = A_WIDTH + B_WIDTH;
   localparam int   EW    = ACC_WIDTH + 3;
   localparam logic L_SGN = (SIGNED != 0);

   // True accumulation result does not fit the ACC_WIDTH result range.
   function automatic logic ovf_chk(input logic [EW-1:0] v);
      if (L_SGN) begin
         ovf_chk = !((&v[EW-1:ACC_WIDTH-1]) || !(|v[EW-1:ACC_WIDTH-1]));
      end else begin
         ovf_chk = |v[EW-1:ACC_WIDTH];
      end
   endfunction

`ifdef MATHBLOCK_MAC_SAT_EN
   function automatic logic [ACC_WIDTH-1:0] clamp_val(input logic neg);
      if (L_SGN) begin
         clamp_val = neg ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
         clamp_val = neg ? {ACC_WIDTH{1'b0}} : {ACC_WIDTH{1'b1}};
      end
   endfunction
`endif

   logic                 w_stall;
   logic                 w_s3_fire;
   logic [PW-1:0]        w_a_x;
   logic [PW-1:0]        w_b_x;
   logic [PW-1:0]        w_prod;
   logic [ACC_WIDTH:0]   w_t;
   logic [EW-1:0]        w_sum;
   logic                 w_beat_ovf;
   logic                 w_frame_ovf;
   logic [ACC_WIDTH-1:0] w_acc_nxt;

   logic                 r_s1_valid, r_s1_sub, r_s1_first, r_s1_last;
   logic [A_WIDTH-1:0]   r_s1_a;
   logic [B_WIDTH-1:0]   r_s1_b;
   logic [C_WIDTH-1:0]   r_s1_c;
   logic                 r_m_valid, r_m_sub, r_m_first, r_m_last;
   logic [PW-1:0]        r_m_prod;
   logic [C_WIDTH-1:0]   r_m_c;
   logic                 r_s2_valid, r_s2_sub, r_s2_first, r_s2_last;
   logic [ACC_WIDTH:0]   r_s2_t;
   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_frame_ovf;
   logic                 r_out_valid;
   logic [ACC_WIDTH-1:0] r_out_p;
   logic                 r_out_ovf;

   // A result waiting on downstream freezes the whole pipeline.
   assign w_stall   = r_out_valid && !out_ready;
   assign in_ready  = !w_stall;
   assign w_s3_fire = !w_stall && r_s2_valid;
   assign out_valid = r_out_valid;
   assign out_p     = r_out_p;
   assign out_ovf   = r_out_ovf;

   // Operand extension and product at full A+B precision.
   always_comb begin
      w_a_x  = {{B_WIDTH{L_SGN & r_s1_a[A_WIDTH-1]}}, r_s1_a};
      w_b_x  = {{A_WIDTH{L_SGN & r_s1_b[B_WIDTH-1]}}, r_s1_b};
      w_prod = w_a_x * w_b_x;
   end

   // Beat term t = A*B + C at ACC_WIDTH+1 bits.
   always_comb begin
      w_t = {{(ACC_WIDTH+1-PW){L_SGN & r_m_prod[PW-1]}}, r_m_prod}
          + {{(ACC_WIDTH+1-C_WIDTH){L_SGN & r_m_c[C_WIDTH-1]}}, r_m_c};
   end

   // Accumulation with headroom wide enough to see the true result.
   always_comb begin
      w_sum = r_s2_first ? {EW{1'b0}} : {{3{L_SGN & r_acc[ACC_WIDTH-1]}}, r_acc};
      if (r_s2_sub) begin
         w_sum = w_sum - {{2{L_SGN & r_s2_t[ACC_WIDTH]}}, r_s2_t};
      end else begin
         w_sum = w_sum + {{2{L_SGN & r_s2_t[ACC_WIDTH]}}, r_s2_t};
      end
      w_beat_ovf  = ovf_chk(w_sum);
      w_frame_ovf = r_s2_first ? w_beat_ovf : (r_frame_ovf | w_beat_ovf);
`ifdef MATHBLOCK_MAC_SAT_EN
      w_acc_nxt   = w_beat_ovf ? clamp_val(w_sum[EW-1]) : w_sum[ACC_WIDTH-1:0];
`else
      w_acc_nxt   = w_sum[ACC_WIDTH-1:0];
`endif
   end

   // S1: input capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= {A_WIDTH{1'b0}};
         r_s1_b     <= {B_WIDTH{1'b0}};
         r_s1_c     <= {C_WIDTH{1'b0}};
         r_s1_sub   <= 1'b0;
         r_s1_first <= 1'b0;
         r_s1_last  <= 1'b0;
      end else if (!w_stall) begin
         r_s1_valid <= in_valid;
         r_s1_a     <= in_a;
         r_s1_b     <= in_b;
         r_s1_c     <= in_c;
         r_s1_sub   <= in_sub;
         r_s1_first <= in_first;
         r_s1_last  <= in_last;
      end else begin
         r_s1_valid <= r_s1_valid;
      end
   end

   // Multiplier pipeline register; C and control ride alongside.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_valid <= 1'b0;
         r_m_prod  <= {PW{1'b0}};
         r_m_c     <= {C_WIDTH{1'b0}};
         r_m_sub   <= 1'b0;
         r_m_first <= 1'b0;
         r_m_last  <= 1'b0;
      end else if (!w_stall) begin
         r_m_valid <= r_s1_valid;
         r_m_prod  <= w_prod;
         r_m_c     <= r_s1_c;
         r_m_sub   <= r_s1_sub;
         r_m_first <= r_s1_first;
         r_m_last  <= r_s1_last;
      end else begin
         r_m_valid <= r_m_valid;
      end
   end

   // S2: beat term register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_t     <= {(ACC_WIDTH+1){1'b0}};
         r_s2_sub   <= 1'b0;
         r_s2_first <= 1'b0;
         r_s2_last  <= 1'b0;
      end else if (!w_stall) begin
         r_s2_valid <= r_m_valid;
         r_s2_t     <= w_t;
         r_s2_sub   <= r_m_sub;
         r_s2_first <= r_m_first;
         r_s2_last  <= r_m_last;
      end else begin
         r_s2_valid <= r_s2_valid;
      end
   end

   // S3: accumulator and sticky frame overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= {ACC_WIDTH{1'b0}};
         r_frame_ovf <= 1'b0;
      end else if (w_s3_fire) begin
         r_acc       <= w_acc_nxt;
         r_frame_ovf <= w_frame_ovf;
      end else begin
         r_acc       <= r_acc;
      end
   end

   // Result register: a completing beat wins over a same-cycle handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_p     <= {ACC_WIDTH{1'b0}};
         r_out_ovf   <= 1'b0;
      end else if (w_s3_fire && r_s2_last) begin
         r_out_valid <= 1'b1;
         r_out_p     <= w_acc_nxt;
         r_out_ovf   <= w_frame_ovf;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= r_out_valid;
      end
   end

endmodule

// File: doc/mathblock_mac_accum.md
# mathblock_mac_accum

Parametrised, pipelined multiply-accumulate block for the SmartFusion2 math-block path; successor to the single-cycle multiply-add. It computes per-beat (A × B) ± C, adds or subtracts the result into a wide accumulator over a frame delimited by first/last flags, and emits one result per frame. Valid/ready handshakes on both sides and full-pipeline backpressure let it sit between streaming DSP stages in the fabric.

## Interface
- A_WIDTH, 18, multiplicand width; 2..18
- B_WIDTH, 18, multiplier width; 2..18
- C_WIDTH, 44, addend width; must be ≤ ACC_WIDTH
- ACC_WIDTH, 44, accumulator and result width; must be ≥ A_WIDTH+B_WIDTH
- SIGNED, 1, 1 = two's-complement operands; 0 = unsigned operands, zero-extended
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- in_a  input  A_WIDTH  multiplicand
- in_b  input  B_WIDTH  multiplier
- in_c  input  C_WIDTH  per-beat addend
- in_sub  input  1  0: acc += A×B + C; 1: acc −= A×B + C
- in_first  input  1  beat starts a frame; accumulator reloads instead of adding
- in_last  input  1  beat ends a frame; result emitted
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_p  output  ACC_WIDTH  frame result
- out_ovf  output  1  an overflow occurred in this frame

## Operation
- A beat transfers when in_valid && in_ready. in_ready = !(out_valid && !out_ready).
- Stall: while out_valid && !out_ready, every pipeline register holds and in_ready = 0. Otherwise all stages advance each cycle.
- Stage S1: registers a, b, c, sub, first, last, and valid.
- Stage S2: registers t = A×B + C. Operands are sign- or zero-extended per SIGNED, then computed at ACC_WIDTH+1 bits.
- Stage S3 (accumulator): on a valid S2 beat:
  - if first: acc = ±t;
  - else: acc = acc ± t.
  - On a first beat, the frame overflow flag is cleared to that beat's overflow; otherwise it is ORed with it.
- Overflow means the true signed (or unsigned) result is not representable in ACC_WIDTH bits.
- Width handling: the accumulator wraps modulo 2^ACC_WIDTH unless saturation is enabled (see Configuration).
- On a valid S3 beat with last set, out_p and out_ovf load and out_valid = 1 in the same cycle the accumulator updates. A first+last beat yields a one-beat frame.
- A beat without first after a completed frame continues from the previous accumulator value (running accumulation). This behaviour is defined, not an error.
- out_valid clears on out_valid && out_ready unless a new last beat lands in the same cycle. When both happen together, the new result loads and out_valid stays 1.
- Reset values (async, on rst_n low): all stage valids 0, acc 0, out_p 0, out_ovf 0, out_valid 0. in_ready is 1 after reset.
- Reset mid-frame discards all in-flight beats and the partial accumulation. No output is produced for that frame.

## Timing
- Latency: a beat accepted at edge k gives out_valid = 1 after edge k+3, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one beat per cycle while out_ready = 1.
- in_ready is combinational from out_valid and out_ready only. There is no path from in_valid to in_ready.
- All outputs other than in_ready are registered.

## Configuration
- MATHBLOCK_MAC_SAT_EN:
  - Defined: on overflow, the accumulator and out_p clamp to the representable extreme in the direction of the true result. For SIGNED=1 this is 2^(ACC_WIDTH−1)−1 or −2^(ACC_WIDTH−1); for SIGNED=0 it is 2^ACC_WIDTH−1 or 0.
  - Undefined: the accumulator wraps.
  - out_ovf is reported identically in both builds.

## Test plan
- Single beat, defaults: a=−3, b=5, c=7, first=last=1, sub=0 → out_p=−8 after 3 cycles, out_ovf=0.
- Frame of 4 back-to-back beats: a=1,2,3,4, b=2, c=0, first on beat 1, last on beat 4 → one result, out_p=20, out_valid for exactly one handshake.
- Subtract mode: beat 1 a=10, b=10, c=0, first; beat 2 a=3, b=3, c=1, sub=1, last → out_p=90.
- Backpressure: out_ready=0 while two frames stream → in_ready drops the cycle out_valid rises, no beat is lost. Releasing out_ready yields results 20 then 90 in order.
- Overflow, with ACC_WIDTH=36 and SIGNED=1: two beats a=b=−131072 (first, then last) → out_ovf=1. out_p=34359738367 with MATHBLOCK_MAC_SAT_EN, −34359738368 without.
- Reset mid-frame: assert rst_n=0 after beat 2 of a 4-beat frame → out_valid=0 and out_p=0 immediately. A new frame a=2, b=2, first+last then gives out_p=4.
